// File: rtl/vga_image_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_image_fetch
// Purpose  : Pixel-data stage between the VGA timing counters and the output
//            pins. Converts the live H/V counts into read addresses for a
//            double-buffered IMG_W x IMG_H 8-bit grayscale image held in
//            block RAM, shown 2x scaled over the 640x480 active area. Sync
//            signals are delayed to stay aligned with the colour.
// Ports    : clk_25MHz     - pixel clock (only clock)
//            reset         - asynchronous active-high reset
//            H/V_count_value - live horizontal / vertical counts
//            h/v_sync_in   - raw syncs aligned with the counts
//            buf_swap_req  - single-cycle request to show the other buffer
//            rd_data       - BRAM data, valid 1 clock after rd_en
//            rd_en/rd_addr - BRAM read strobe / {buf_sel, pixel index}
//            buf_sel       - buffer being displayed
//            frame_start   - one-cycle pulse after each frame boundary
//            h_sync/v_sync - syncs delayed 2 clocks
//            vga_r/g/b     - 4-bit grayscale colour
// Revision : 1.0 - initial release
// ============================================================================
module vga_image_fetch #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk_25MHz,
  input  logic              reset,
  input  logic [9:0]        H_count_value,
  input  logic [9:0]        V_count_value,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic              buf_swap_req,
  input  logic [7:0]        rd_data,
  output logic              rd_en,
  output logic [ADDR_W:0]   rd_addr,
  output logic              buf_sel,
  output logic              frame_start,
  output logic              h_sync,
  output logic              v_sync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b
);

  localparam logic [9:0] H_ACT_START = 10'd144;
  localparam logic [9:0] H_ACT_END   = 10'(144 + 2 * IMG_W - 1);
  localparam logic [9:0] V_ACT_START = 10'd35;
  localparam logic [9:0] V_ACT_END   = 10'(35 + 2 * IMG_H - 1);

  // ---------------------------------------------------------------- state
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  logic              von1_q, von1_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;
  logic              von2_q, von2_d;
  logic              h_sync_q, h_sync_d;
  logic              v_sync_q, v_sync_d;
  logic              buf_sel_q, buf_sel_d;
  logic              swap_pending_q, swap_pending_d;
  logic              frame_start_q, frame_start_d;

  // ---------------------------------------------------------- decode
  logic [9:0]        h_rel;
  logic [9:0]        v_rel;
  logic              h_act;
  logic              v_act;
  logic              video_on;
  logic              at_line_start;
  logic              at_first_pixel;
  logic              at_line_end;
  logic              at_boundary;
  logic [ADDR_W-1:0] col_cur;
  logic [ADDR_W-1:0] base_cur;
  logic [ADDR_W-1:0] pix_idx;
  logic [3:0]        pix;
  logic              unused_rd_low;

  always_comb begin
    h_rel          = H_count_value - H_ACT_START;
    v_rel          = V_count_value - V_ACT_START;
    h_act          = (H_count_value >= H_ACT_START) && (H_count_value <= H_ACT_END);
    v_act          = (V_count_value >= V_ACT_START) && (V_count_value <= V_ACT_END);
    video_on       = h_act && v_act;
    at_line_start  = (H_count_value == H_ACT_START);
    at_first_pixel = at_line_start && (V_count_value == V_ACT_START);
    at_line_end    = (H_count_value == H_ACT_END);
    at_boundary    = (H_count_value == 10'd0) && (V_count_value == 10'd0);

    // The clear points must already apply to the cycle that triggers them,
    // so the addressed value is overridden here as well as in the flop.
    col_cur  = at_line_start  ? '0 : col_q;
    base_cur = at_first_pixel ? '0 : line_base_q;
    pix_idx  = base_cur + col_cur;
  end

  // ---------------------------------------------------- next-state logic
  always_comb begin
    // Column advances after the second pixel of each pair (odd offset).
    col_d = col_q;
    if (at_line_start) begin
      col_d = '0;
    end else if (video_on && h_rel[0]) begin
      col_d = col_q + 1'b1;
    end

    // Each image row spans two display lines; step the base after the
    // second one (odd line offset).
    line_base_d = line_base_q;
    if (at_first_pixel) begin
      line_base_d = '0;
    end else if (at_line_end && v_act && v_rel[0]) begin
      line_base_d = line_base_q + ADDR_W'(IMG_W);
    end

    // Stage 1: read request, address held outside the active area.
    rd_en_d   = video_on;
    rd_addr_d = video_on ? {buf_sel_q, pix_idx} : rd_addr_q;
    von1_d    = video_on;
    hs1_d     = h_sync_in;
    vs1_d     = v_sync_in;

    // Stage 2: colour gate and sync delay.
    von2_d   = von1_q;
    h_sync_d = hs1_q;
    v_sync_d = vs1_q;

    // Buffer swap only at the frame boundary; a request landing on the
    // boundary cycle itself is taken there and leaves nothing pending.
    buf_sel_d      = buf_sel_q;
    swap_pending_d = swap_pending_q;
    if (at_boundary && (swap_pending_q || buf_swap_req)) begin
      buf_sel_d      = ~buf_sel_q;
      swap_pending_d = 1'b0;
    end else if (buf_swap_req) begin
      swap_pending_d = 1'b1;
    end

    frame_start_d = at_boundary;
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      line_base_q    <= '0;
      col_q          <= '0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      von1_q         <= 1'b0;
      hs1_q          <= 1'b0;
      vs1_q          <= 1'b0;
      von2_q         <= 1'b0;
      h_sync_q       <= 1'b0;
      v_sync_q       <= 1'b0;
      buf_sel_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      line_base_q    <= line_base_d;
      col_q          <= col_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      von1_q         <= von1_d;
      hs1_q          <= hs1_d;
      vs1_q          <= vs1_d;
      von2_q         <= von2_d;
      h_sync_q       <= h_sync_d;
      v_sync_q       <= v_sync_d;
      buf_sel_q      <= buf_sel_d;
      swap_pending_q <= swap_pending_d;
      frame_start_q  <= frame_start_d;
    end
  end

  // The BRAM output is itself registered and becomes valid in the same
  // cycle as the delayed video_on, so the colour is that data gated by the
  // registered enable; the gate flop holds the output at 0 during reset.
  assign pix           = von2_q ? rd_data[7:4] : 4'h0;
  assign unused_rd_low = ^rd_data[3:0];

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign buf_sel     = buf_sel_q;
  assign frame_start = frame_start_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign vga_r       = pix;
  assign vga_g       = pix;
  assign vga_b       = pix;

endmodule
`default_nettype wire
